sync_bus_capture: RTL and testbench

SYNC_BUS_CAPTURE -- requirements
Module: sync_bus_capture

---
 rtl/sync_capture_pkg.sv | 12 +
 rtl/sync_bus_capture_counter.sv | 44 ++++
 rtl/sync_bus_capture.sv | 85 ++++++++
 tb/tb_sync_bus_capture.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sync_capture_pkg.sv
// Shared types and widths for the synchronized-bus capture block.
package sync_capture_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int CNT_W = 8;
  localparam int OVR_W = 8;

endpackage

// File: rtl/sync_bus_capture_counter.sv
// Stability qualifier: tracks how long data_in has matched the previous sample.
module sample_stability_counter
  import sync_capture_pkg::*;
#(
  parameter int M             = 15,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk_out,
  input  logic         rst,
  input  logic [M-1:0] data_in,
  output logic [M-1:0] prev,
  output logic         stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [M-1:0]     prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Any difference restarts qualification; otherwise count up and hold at the top.
  always_comb begin
    cnt_next = cnt_reg;
    if (data_in != prev_reg) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      prev_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      prev_reg <= data_in;
      cnt_reg  <= cnt_next;
    end
  end

  assign prev   = prev_reg;
  assign stable = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/sync_bus_capture.sv
// Commits a bus value once it has been stable for STABLE_CYCLES samples and offers it with valid/ready.
// Optional overwrite counter enabled by defining SYNC_CAPTURE_OVERRUN_EN.
module sync_bus_capture
  import sync_capture_pkg::*;
#(
  parameter int M             = 15,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic [M-1:0]     data_in,
  input  logic             ready,
`ifdef SYNC_CAPTURE_OVERRUN_EN
  output logic [OVR_W-1:0] overrun_cnt,
`endif
  output logic [M-1:0]     data_out,
  output logic             valid
);

  logic [M-1:0] prev;
  logic         stable;
  logic         commit;
  logic         transfer;
  state_t       state_reg;
  state_t       state_next;
  logic [M-1:0] data_out_reg;

  sample_stability_counter #(
    .M             (M),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stability (
    .clk_out (clk_out),
    .rst     (rst),
    .data_in (data_in),
    .prev    (prev),
    .stable  (stable)
  );

  // A value already on data_out never recommits, so a held value commits once.
  assign commit   = stable && (prev != data_out_reg);
  assign transfer = (state_reg == PENDING) && ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (commit) state_next = PENDING;
      PENDING: if (transfer && !commit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      data_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (commit) begin
        data_out_reg <= prev;
      end
    end
  end

  assign data_out = data_out_reg;
  assign valid    = (state_reg == PENDING);

`ifdef SYNC_CAPTURE_OVERRUN_EN
  logic [OVR_W-1:0] overrun_reg;
  logic             overwrite;

  // Replacing an unaccepted value; a same-edge transfer is not an overrun.
  assign overwrite = commit && (state_reg == PENDING) && !ready;

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      overrun_reg <= '0;
    end else if (overwrite && (overrun_reg != '1)) begin
      overrun_reg <= overrun_reg + OVR_W'(1);
    end
  end

  assign overrun_cnt = overrun_reg;
`endif

endmodule

// File: tb/tb_sync_bus_capture.sv
// Directed vector bench for sync_bus_capture (M=15, STABLE_CYCLES=4).
module tb_sync_bus_capture;

  logic        clk_out = 1'b0;
  logic        rst     = 1'b1;
  logic [14:0] data_in = '0;
  logic        ready   = 1'b0;
  logic [14:0] data_out;
  logic        valid;
`ifdef SYNC_CAPTURE_OVERRUN_EN
  logic [7:0]  overrun_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int xfers  = 0;

  typedef struct {
    logic [14:0] din;
    logic        rdy;
    logic [14:0] exp_dout;
    logic        exp_valid;
    logic        count_xfer;
  } vec_t;

  vec_t vecs[$];

  sync_bus_capture #(
    .M             (15),
    .STABLE_CYCLES (4)
  ) dut (
    .clk_out     (clk_out),
    .rst         (rst),
    .data_in     (data_in),
    .ready       (ready),
`ifdef SYNC_CAPTURE_OVERRUN_EN
    .overrun_cnt (overrun_cnt),
`endif
    .data_out    (data_out),
    .valid       (valid)
  );

  always #5 clk_out = ~clk_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic addn(input int n, input logic [14:0] din, input logic rdy,
                      input logic [14:0] ed, input logic ev, input logic cx);
    vec_t v;
    v.din        = din;
    v.rdy        = rdy;
    v.exp_dout   = ed;
    v.exp_valid  = ev;
    v.count_xfer = cx;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk_out);
    #1;
  endtask

  task automatic hold(input logic [14:0] din, input logic rdy, input int n);
    repeat (n) begin
      data_in = din;
      ready   = rdy;
      step();
    end
  endtask

  initial begin
    // Idle zeros after reset, then 0x1234 held (valid on 4th edge after first sample)
    addn(5,  15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0);
    addn(4,  15'h1234, 1'b0, 15'h0000, 1'b0, 1'b0);
    addn(2,  15'h1234, 1'b0, 15'h1234, 1'b1, 1'b0);
    addn(1,  15'h1234, 1'b1, 15'h1234, 1'b0, 1'b0);
    // Return data_out to zero so the transient test starts from a known value
    addn(4,  15'h0000, 1'b0, 15'h1234, 1'b0, 1'b0);
    addn(1,  15'h0000, 1'b0, 15'h0000, 1'b1, 1'b0);
    addn(1,  15'h0000, 1'b1, 15'h0000, 1'b0, 1'b0);
    // Short runs of 0x1234 and 0x7FFF must not commit; 0x0001 held does
    addn(3,  15'h1234, 1'b0, 15'h0000, 1'b0, 1'b0);
    addn(1,  15'h7FFF, 1'b0, 15'h0000, 1'b0, 1'b0);
    addn(4,  15'h0001, 1'b0, 15'h0000, 1'b0, 1'b0);
    addn(2,  15'h0001, 1'b0, 15'h0001, 1'b1, 1'b0);
    addn(1,  15'h0001, 1'b1, 15'h0001, 1'b0, 1'b0);
    // 0x0055 held 20 cycles with ready=1: one transfer only
    addn(4,  15'h0055, 1'b1, 15'h0001, 1'b0, 1'b1);
    addn(1,  15'h0055, 1'b1, 15'h0055, 1'b1, 1'b1);
    addn(15, 15'h0055, 1'b1, 15'h0055, 1'b0, 1'b1);

    // Reset: inputs ignored while asserted
    data_in = 15'h1234;
    step();
    step();
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
`ifdef SYNC_CAPTURE_OVERRUN_EN
    check("reset_overrun", 32'(overrun_cnt), 32'h0);
`endif
    data_in = 15'h0000;
    step();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      data_in = vecs[i].din;
      ready   = vecs[i].rdy;
      if (vecs[i].count_xfer && valid && ready) xfers++;
      step();
      $display("vec %0d din=%h rdy=%b -> data_out=%h valid=%b", i, vecs[i].din, vecs[i].rdy,
               data_out, valid);
      check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
    end
    check("held_0x55_transfers", 32'(xfers), 32'd1);

    // Overwrite of an unaccepted value
    hold(15'h0010, 1'b0, 5);
    $display("seq commit 0x0010 -> data_out=%h valid=%b", data_out, valid);
    check("commit10_data_out", 32'(data_out), 32'h0010);
    check("commit10_valid", 32'(valid), 32'h1);
    hold(15'h0020, 1'b0, 5);
    $display("seq overwrite 0x0020 -> data_out=%h valid=%b", data_out, valid);
    check("overwrite20_data_out", 32'(data_out), 32'h0020);
    check("overwrite20_valid", 32'(valid), 32'h1);
`ifdef SYNC_CAPTURE_OVERRUN_EN
    check("overwrite20_overrun", 32'(overrun_cnt), 32'h1);
`endif

    // Transfer of 0x0010 on the same edge as the commit of 0x0020
    hold(15'h0020, 1'b1, 1);
    check("accept20_valid", 32'(valid), 32'h0);
    hold(15'h0010, 1'b0, 5);
    check("pend10_data_out", 32'(data_out), 32'h0010);
    hold(15'h0020, 1'b0, 4);
    check("pre_commit_data_out", 32'(data_out), 32'h0010);
    hold(15'h0020, 1'b1, 1);
    $display("seq commit+transfer -> data_out=%h valid=%b", data_out, valid);
    check("same_edge_data_out", 32'(data_out), 32'h0020);
    check("same_edge_valid", 32'(valid), 32'h1);
`ifdef SYNC_CAPTURE_OVERRUN_EN
    check("same_edge_overrun", 32'(overrun_cnt), 32'h1);
`endif
    hold(15'h0020, 1'b0, 1);
    check("after_same_edge_valid", 32'(valid), 32'h1);

    // Asynchronous reset while a value is pending
    hold(15'h0AAA, 1'b0, 5);
    check("pend_aaa_data_out", 32'(data_out), 32'h0AAA);
`ifdef SYNC_CAPTURE_OVERRUN_EN
    check("pend_aaa_overrun", 32'(overrun_cnt), 32'h2);
`endif
    #2;
    rst = 1'b1;
    #1;
    $display("seq async reset -> data_out=%h valid=%b", data_out, valid);
    check("async_rst_data_out", 32'(data_out), 32'h0);
    check("async_rst_valid", 32'(valid), 32'h0);
`ifdef SYNC_CAPTURE_OVERRUN_EN
    check("async_rst_overrun", 32'(overrun_cnt), 32'h0);
`endif
    step();
    check("rst_held_valid", 32'(valid), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("recommit_wait%0d_valid", k), 32'(valid), 32'h0);
    end
    step();
    $display("seq recommit after reset -> data_out=%h valid=%b", data_out, valid);
    check("recommit_data_out", 32'(data_out), 32'h0AAA);
    check("recommit_valid", 32'(valid), 32'h1);

    // 256 overwrites saturate the overrun counter
    for (int k = 0; k < 256; k++) begin
      hold((k % 2 == 1) ? 15'h0200 : 15'h0100, 1'b0, 5);
`ifdef SYNC_CAPTURE_OVERRUN_EN
      if (k == 9)   check("overrun_10", 32'(overrun_cnt), 32'd10);
      if (k == 254) check("overrun_255", 32'(overrun_cnt), 32'd255);
`endif
    end
    $display("seq 256 overwrites -> data_out=%h valid=%b", data_out, valid);
    check("sat_data_out", 32'(data_out), 32'h0200);
    check("sat_valid", 32'(valid), 32'h1);
`ifdef SYNC_CAPTURE_OVERRUN_EN
    check("overrun_sat", 32'(overrun_cnt), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
